reg_wb_buffer: RTL and testbench

- Write-back buffer that sits directly upstream of the 32x32 register file write port.
- Accepts register write requests from the execute stage via a valid/ready handshake and queues them in a small in-order FIFO.
- Drains one entry per cycle into the register file write port (wen/waddr/wdata).
- Forwards the youngest pending value for each of the two read ports, so readers never see stale register-file data while a write is still queued.

---
 rtl/reg_wb_buffer.sv | 82 ++++++++
 tb/tb_reg_wb_buffer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/reg_wb_buffer.sv
// reg_wb_buffer: in-order write-back FIFO in front of the register file write port,
// with youngest-entry forwarding for both read ports.
module reg_wb_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     wen,
    output logic [AW-1:0]            waddr,
    output logic [DW-1:0]            wdata,
    input  logic [AW-1:0]            raddr1,
    input  logic [AW-1:0]            raddr2,
    input  logic [DW-1:0]            rf_rdata1,
    input  logic [DW-1:0]            rf_rdata2,
    output logic [DW-1:0]            rdata1,
    output logic [DW-1:0]            rdata2,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    a_q [DEPTH];
    logic [DW-1:0]    d_q [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [PW-1:0]    head, tail;
    logic             push;

    assign in_ready = count != CW'(DEPTH);
    assign wen      = (count != '0) & ~stall;
    assign waddr    = (count != '0) ? a_q[head] : '0;
    assign wdata    = (count != '0) ? d_q[head] : '0;
    assign push     = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            v_q   <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            v_q   <= '0;
        end else begin
            if (push)
                tail <= tail + PW'(1);
            if (wen)
                head <= head + PW'(1);
            v_q   <= (v_q & ~(wen ? DEPTH'(1) << head : '0)) | (push ? DEPTH'(1) << tail : '0);
            count <= count + CW'(push) - CW'(wen);
        end
    end

    // payload needs no reset: v_q and count gate every use of it
    always_ff @(posedge clk) begin
        if (push) begin
            a_q[tail] <= in_addr;
            d_q[tail] <= in_data;
        end
    end

    // walk oldest to youngest so the youngest match wins
    always_comb begin
        rdata1 = rf_rdata1;
        rdata2 = rf_rdata2;
        for (int i = 0; i < DEPTH; i++) begin
            if (v_q[head + PW'(i)] && a_q[head + PW'(i)] == raddr1)
                rdata1 = d_q[head + PW'(i)];
            if (v_q[head + PW'(i)] && a_q[head + PW'(i)] == raddr2)
                rdata2 = d_q[head + PW'(i)];
        end
    end
endmodule

// File: tb/tb_reg_wb_buffer.sv
// tb_reg_wb_buffer: directed scoreboard bench for reg_wb_buffer.
module tb_reg_wb_buffer;
    localparam int D = 4;

    logic        clk = 0, rst = 0, in_valid = 0, stall = 0, flush = 0;
    logic        in_ready, wen;
    logic [4:0]  in_addr = 0, waddr, raddr1 = 0, raddr2 = 0;
    logic [31:0] in_data = 0, wdata, rf_rdata1 = 32'hCAFE0001, rf_rdata2 = 32'hCAFE0002, rdata1, rdata2;
    logic [2:0]  count;

    typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t q[$];
    int checks = 0, errs = 0;

    reg_wb_buffer #(.DEPTH(D), .AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .stall(stall), .flush(flush),
        .wen(wen), .waddr(waddr), .wdata(wdata), .raddr1(raddr1), .raddr2(raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .rdata1(rdata1), .rdata2(rdata2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // check all outputs against the queue model, then advance one edge
    task automatic cyc();
        logic        ew, acc;
        logic [31:0] f1, f2;
        @(negedge clk);
        ew = q.size() != 0 && !stall;
        chk("in_ready", 32'(in_ready), 32'(q.size() != D));
        chk("count", 32'(count), 32'(q.size()));
        chk("wen", 32'(wen), 32'(ew));
        chk("waddr", 32'(waddr), q.size() != 0 ? 32'(q[0].a) : 32'h0);
        chk("wdata", wdata, q.size() != 0 ? q[0].d : 32'h0);
        f1 = rf_rdata1;
        f2 = rf_rdata2;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].a == raddr1) f1 = q[i].d;
            if (q[i].a == raddr2) f2 = q[i].d;
        end
        chk("rdata1", rdata1, f1);
        chk("rdata2", rdata2, f2);
        acc = in_valid && q.size() != D && !flush && rst;
        @(posedge clk);
        if (!rst || flush) q.delete();
        else begin
            if (ew) void'(q.pop_front());
            if (acc) q.push_back({in_addr, in_data});
        end
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        in_valid = 1; in_addr = a; in_data = d;
        cyc();
        in_valid = 0;
    endtask

    initial begin
        #2;
        chk("rst_wen", 32'(wen), 0);
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_rdata1", rdata1, 32'hCAFE0001);
        chk("rst_rdata2", rdata2, 32'hCAFE0002);
        @(posedge clk); #1 rst = 1;

        // single write
        push(5'd3, 32'h11);
        chk("single_wen", 32'(wen), 1);
        chk("single_waddr", 32'(waddr), 3);
        cyc(); cyc();

        // fill and backpressure
        stall = 1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'hA0 + 32'(i));
        chk("full_ready", 32'(in_ready), 0);
        push(5'd7, 32'hBAD);
        chk("full_count", 32'(count), 4);
        stall = 0;
        repeat (6) cyc();

        // youngest forwarding
        stall = 1;
        push(5'd5, 32'h100);
        push(5'd5, 32'h200);
        raddr1 = 5; rf_rdata1 = 32'hDEAD; raddr2 = 6; rf_rdata2 = 32'hBEEF;
        #1;
        chk("fwd_young", rdata1, 32'h200);
        chk("fwd_miss", rdata2, 32'hBEEF);
        cyc();
        raddr2 = 5;
        stall = 0;
        cyc();
        chk("fwd_head_only", rdata1, 32'h200);
        repeat (3) cyc();

        // sustained push/pop at count=2 across wrap-around
        stall = 1;
        push(5'd8, 32'h300);
        push(5'd9, 32'h301);
        stall = 0;
        in_valid = 1;
        for (int i = 0; i < 3 * D; i++) begin
            in_addr = 5'(10 + i); in_data = $urandom; raddr1 = 5'(9 + i);
            cyc();
            chk("pp_count", 32'(count), 2);
        end
        in_valid = 0;
        repeat (4) cyc();

        // flush with a concurrent push
        stall = 1;
        push(5'd1, 32'h401); push(5'd2, 32'h402); push(5'd3, 32'h403);
        stall = 0; flush = 1; in_valid = 1; in_addr = 5'd4; in_data = 32'h404; raddr1 = 2; raddr2 = 4;
        cyc();
        flush = 0; in_valid = 0;
        chk("flush_count", 32'(count), 0);
        chk("flush_wen", 32'(wen), 0);
        chk("flush_rd1", rdata1, rf_rdata1);
        chk("flush_rd2", rdata2, rf_rdata2);
        cyc(); cyc();

        // async reset mid-drain
        stall = 1;
        push(5'd0, 32'h500); push(5'd1, 32'h501); push(5'd2, 32'h502);
        stall = 0;
        @(negedge clk);
        chk("pre_rst_wen", 32'(wen), 1);
        #1 rst = 0;
        #1;
        chk("arst_wen", 32'(wen), 0);
        chk("arst_count", 32'(count), 0);
        q.delete();
        @(posedge clk); #1 rst = 1;
        push(5'd12, 32'h600);
        chk("post_rst_waddr", 32'(waddr), 12);
        chk("post_rst_wdata", wdata, 32'h600);
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
